// File: rtl/fround_pkg.sv
// Shared types and constants for the FP32 round-to-integral pipeline.
// Holds the rounding-mode enum, the IEEE-754 single constants used by the
// datapath and the payload structs carried between pipeline stages.
package fround_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rm_e;

  // Which datapath a classified operand takes through the later stages.
  typedef enum logic [1:0] {
    PathPass  = 2'd0,
    PathSmall = 2'd1,
    PathNorm  = 2'd2
  } path_e;

  localparam int unsigned FP_BIAS    = 127;
  localparam int unsigned FP_EXP_INT = 150;
  localparam logic [31:0] FP_ONE     = 32'h3F800000;
  localparam logic [31:0] FP_QBIT    = 32'h00400000;

  // Stage 1 -> stage 2 payload.
  typedef struct packed {
    logic [31:0] x;
    rm_e         rm;
    path_e       path;
    logic [4:0]  f;     // fraction bit count on the normal path, 1..23
  } cls_t;

  // Stage 2 -> stage 3 payload.
  typedef struct packed {
    logic [31:0] x;
    path_e       path;
    logic [4:0]  f;
    logic        up;
  } dec_t;

  // Encodings 101..111 are not defined and fall back to round-to-nearest-even.
  function automatic rm_e rm_decode(input logic [2:0] rm);
    unique case (rm)
      3'd1:    return RTZ;
      3'd2:    return RDN;
      3'd3:    return RUP;
      3'd4:    return RMM;
      default: return RNE;
    endcase
  endfunction

endpackage

// File: rtl/fround_core.sv
// Combinational stage logic of the FP32 round-to-integral pipeline.
// Optional macro FROUND_FLAGS_EN adds the inexact / invalid flag outputs.
// Ports:
//   in_x, in_rm  raw operand and mode        -> cls   (classify result)
//   cls_r        registered classify payload -> dec   (round-up decision)
//   dec_r        registered decide payload   -> res_y (assembled result)
//   res_nx, res_nv (FROUND_FLAGS_EN only) flags aligned with res_y
module fround_core
  import fround_pkg::*;
(
  input  logic [31:0] in_x,
  input  logic [2:0]  in_rm,
  output cls_t        cls,
  input  cls_t        cls_r,
  output dec_t        dec,
  input  dec_t        dec_r,
  output logic [31:0] res_y
`ifdef FROUND_FLAGS_EN
  ,
  output logic        res_nx,
  output logic        res_nv
`endif
);

  // Stage 1: classify by exponent.
  logic [7:0] cls_e;

  always_comb begin
    cls_e    = in_x[30:23];
    cls      = '0;
    cls.x    = in_x;
    cls.rm   = rm_decode(in_rm);
    cls.path = PathPass;
    if (cls_e == 8'hFF || cls_e >= 8'(FP_EXP_INT)) begin
      cls.path = PathPass;
    end else if (cls_e < 8'(FP_BIAS)) begin
      cls.path = PathSmall;
    end else begin
      cls.path = PathNorm;
      cls.f    = 5'(8'(FP_EXP_INT) - cls_e);
    end
  end

  // Stage 2: decide whether the magnitude rounds up.
  logic [31:0] dec_mask;
  logic        dec_inexact, dec_half, dec_sticky, dec_lsb;
  logic        dec_sign, dec_nonzero, dec_e126, dec_mant_nz;
  logic        norm_up, small_up;

  always_comb begin
    dec_mask    = (32'd1 << cls_r.f) - 32'd1;
    dec_inexact = |(cls_r.x & dec_mask);
    dec_half    = cls_r.x[cls_r.f - 5'd1];
    dec_sticky  = |(cls_r.x & (dec_mask >> 1));
    dec_lsb     = cls_r.x[cls_r.f];
    dec_sign    = cls_r.x[31];
    dec_nonzero = |cls_r.x[30:0];
    dec_e126    = (cls_r.x[30:23] == 8'd126);
    dec_mant_nz = |cls_r.x[22:0];

    unique case (cls_r.rm)
      RTZ:     norm_up = 1'b0;
      RDN:     norm_up = dec_sign & dec_inexact;
      RUP:     norm_up = ~dec_sign & dec_inexact;
      RMM:     norm_up = dec_half;
      default: norm_up = dec_half & (dec_sticky | dec_lsb);
    endcase

    // |x| < 1: the only candidate results are 0 and 1.
    unique case (cls_r.rm)
      RTZ:     small_up = 1'b0;
      RDN:     small_up = dec_sign & dec_nonzero;
      RUP:     small_up = ~dec_sign & dec_nonzero;
      RMM:     small_up = dec_e126;
      default: small_up = dec_e126 & dec_mant_nz;
    endcase

    dec      = '0;
    dec.x    = cls_r.x;
    dec.path = cls_r.path;
    dec.f    = cls_r.f;
    unique case (cls_r.path)
      PathNorm:  dec.up = norm_up;
      PathSmall: dec.up = small_up & dec_nonzero;
      default:   dec.up = 1'b0;
    endcase
  end

  // Stage 3: assemble the result; an increment carry ripples into the exponent.
  logic [31:0] asm_mask, asm_inc;
  logic        asm_snan;

  always_comb begin
    asm_mask = (32'd1 << dec_r.f) - 32'd1;
    asm_inc  = dec_r.up ? (32'd1 << dec_r.f) : 32'd0;
    asm_snan = (dec_r.x[30:23] == 8'hFF) & (|dec_r.x[22:0]) & ~dec_r.x[22];
    unique case (dec_r.path)
      PathNorm:  res_y = {dec_r.x[31], (dec_r.x[30:0] & ~asm_mask[30:0]) + asm_inc[30:0]};
      PathSmall: res_y = {dec_r.x[31], dec_r.up ? FP_ONE[30:0] : 31'd0};
      default: begin
        res_y = dec_r.x;
`ifdef FROUND_FLAGS_EN
        if (asm_snan) res_y = dec_r.x | FP_QBIT;
`endif
      end
    endcase
  end

`ifdef FROUND_FLAGS_EN
  assign res_nv = asm_snan;
  assign res_nx = (dec_r.x[30:23] != 8'hFF) & (res_y != dec_r.x);
`else
  logic unused_snan;
  assign unused_snan = asm_snan;
`endif

endmodule

// File: rtl/fround_pipe.sv
// Pipelined FP32 round-to-integral-value unit (RNE/RTZ/RDN/RUP/RMM).
// Optional macro FROUND_FLAGS_EN adds out_nx (inexact) and out_nv (sNaN input,
// quieted on output); without it NaNs pass bit-exact.
// Parameters: STAGES (>= 3) input-to-output latency, TAG_W tag width.
// Ports:
//   clk, rst                        clock, async active-high reset
//   in_valid/in_ready/in_x/in_rm/in_tag   operation input handshake
//   out_valid/out_ready/out_y/out_tag     result output handshake
module fround_pipe
  import fround_pkg::*;
#(
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag
`ifdef FROUND_FLAGS_EN
  ,
  output logic             out_nx,
  output logic             out_nv
`endif
);

  // Result registers: index 0 is stage 3, the rest are pure delay.
  localparam int unsigned NOut = STAGES - 2;

  logic stall;

  cls_t             cls_d, s1_q;
  dec_t             dec_d, s2_q;
  logic [31:0]      res_y;
  logic             s1_valid_q, s2_valid_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;

  logic             o_valid_q [NOut];
  logic [31:0]      o_y_q     [NOut];
  logic [TAG_W-1:0] o_tag_q   [NOut];

`ifdef FROUND_FLAGS_EN
  logic res_nx, res_nv;
  logic o_nx_q [NOut];
  logic o_nv_q [NOut];
`endif

  // One global stall: a blocked output freezes every stage.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  fround_core u_core (
    .in_x   (in_x),
    .in_rm  (in_rm),
    .cls    (cls_d),
    .cls_r  (s1_q),
    .dec    (dec_d),
    .dec_r  (s2_q),
    .res_y  (res_y)
`ifdef FROUND_FLAGS_EN
    ,
    .res_nx (res_nx),
    .res_nv (res_nv)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_tag_q   <= '0;
      for (int unsigned i = 0; i < NOut; i++) begin
        o_valid_q[i] <= 1'b0;
        o_y_q[i]     <= '0;
        o_tag_q[i]   <= '0;
`ifdef FROUND_FLAGS_EN
        o_nx_q[i]    <= 1'b0;
        o_nv_q[i]    <= 1'b0;
`endif
      end
    end else if (!stall) begin
      // Not stalled implies in_ready, so in_valid alone means a transfer.
      s1_valid_q   <= in_valid;
      s1_q         <= cls_d;
      s1_tag_q     <= in_tag;
      s2_valid_q   <= s1_valid_q;
      s2_q         <= dec_d;
      s2_tag_q     <= s1_tag_q;
      o_valid_q[0] <= s2_valid_q;
      o_y_q[0]     <= res_y;
      o_tag_q[0]   <= s2_tag_q;
`ifdef FROUND_FLAGS_EN
      o_nx_q[0]    <= res_nx;
      o_nv_q[0]    <= res_nv;
`endif
      for (int unsigned i = 1; i < NOut; i++) begin
        o_valid_q[i] <= o_valid_q[i-1];
        o_y_q[i]     <= o_y_q[i-1];
        o_tag_q[i]   <= o_tag_q[i-1];
`ifdef FROUND_FLAGS_EN
        o_nx_q[i]    <= o_nx_q[i-1];
        o_nv_q[i]    <= o_nv_q[i-1];
`endif
      end
    end
  end

  assign out_valid = o_valid_q[NOut-1];
  assign out_y     = o_y_q[NOut-1];
  assign out_tag   = o_tag_q[NOut-1];
`ifdef FROUND_FLAGS_EN
  assign out_nx    = o_nx_q[NOut-1];
  assign out_nv    = o_nv_q[NOut-1];
`endif

endmodule

// File: tb/tb_fround_pipe.sv
// Self-checking bench for fround_pipe: two instances (STAGES=3 and STAGES=5),
// an integer-arithmetic rounding model and a per-cycle scoreboard.
module tb_fround_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]      in_x;
  logic [2:0]       in_rm;
  logic [4:0]       in_tag;
  logic [1:0]       inv, ordy, rdy, ov;
  logic [1:0][31:0] oy;
  logic [1:0][4:0]  otag;
  logic [1:0]       onx, onv;

`ifndef FROUND_FLAGS_EN
  assign onx = '0;
  assign onv = '0;
`endif

  fround_pipe #(.STAGES(3), .TAG_W(5)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(inv[0]), .in_ready(rdy[0]), .in_x(in_x),
    .in_rm(in_rm), .in_tag(in_tag), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_y(oy[0]), .out_tag(otag[0])
`ifdef FROUND_FLAGS_EN
    , .out_nx(onx[0]), .out_nv(onv[0])
`endif
  );

  fround_pipe #(.STAGES(5), .TAG_W(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(inv[1]), .in_ready(rdy[1]), .in_x(in_x),
    .in_rm(in_rm), .in_tag(in_tag), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_y(oy[1]), .out_tag(otag[1])
`ifdef FROUND_FLAGS_EN
    , .out_nx(onx[1]), .out_nv(onv[1])
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: round the magnitude with integer arithmetic, then re-encode.
  function automatic logic [31:0] ref_round(input logic [31:0] x, input logic [2:0] rm_in);
    logic              s, up;
    int                e, sh, p;
    logic [2:0]        rm;
    longint unsigned   m, fl, rem, half, n, mant;
    s  = x[31];
    e  = int'(x[30:23]);
    rm = (rm_in > 3'd4) ? 3'd0 : rm_in;
    if (e == 255) begin
`ifdef FROUND_FLAGS_EN
      if (x[22:0] != 23'd0 && !x[22]) return x | 32'h00400000;
`endif
      return x;
    end
    if (e >= 150) return x;
    m  = (e == 0) ? {41'd0, x[22:0]} : {40'd0, 1'b1, x[22:0]};
    sh = (e == 0) ? 149 : 150 - e;
    if (sh > 40) sh = 40;
    fl   = m >> sh;
    rem  = m - (fl << sh);
    half = 64'd1 << (sh - 1);
    case (rm)
      3'd0:    up = (rem > half) || (rem == half && fl[0]);
      3'd1:    up = 1'b0;
      3'd2:    up = s && rem != 0;
      3'd3:    up = !s && rem != 0;
      default: up = rem >= half;
    endcase
    n = fl + {63'd0, up};
    if (n == 0) return {s, 31'd0};
    p = 0;
    for (int i = 0; i < 64; i++) if (n[i]) p = i;
    mant = (p >= 23) ? (n >> (p - 23)) : (n << (23 - p));
    return {s, 8'(127 + p), mant[22:0]};
  endfunction

  function automatic logic ref_nv(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 23'd0 && !x[22];
  endfunction

  typedef struct {
    logic [31:0] y;
    logic [4:0]  tag;
    logic        nx;
    logic        nv;
    int          acc_cyc;
    int          acc_stalls;
  } exp_t;

  exp_t sb [2][64];
  int   wr [2];
  int   rd [2];
  int   stalls [2];
  logic seen [2];
  exp_t ce;
  int   lat;

  // Scoreboard: push on accepted input, check and pop on output transfer.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wr[i] = 0; rd[i] = 0; seen[i] = 1'b0; stalls[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ov[i]) begin
          if (rd[i] == wr[i]) begin
            total++; bad++;
            $display("FAIL unexpected_out inst=%0d: got y=%h tag=%0d want no result",
                     i, oy[i], otag[i]);
          end else begin
            ce = sb[i][rd[i] % 64];
            if (!seen[i]) begin
              seen[i] = 1'b1;
              lat = cyc - ce.acc_cyc - (stalls[i] - ce.acc_stalls);
              chk($sformatf("latency inst=%0d tag=%0d", i, ce.tag), 32'(lat),
                  (i == 0) ? 32'd3 : 32'd5);
            end
            if (ordy[i]) begin
              chk($sformatf("out_y inst=%0d tag=%0d", i, ce.tag), oy[i], ce.y);
              chk($sformatf("out_tag inst=%0d", i), 32'(otag[i]), 32'(ce.tag));
`ifdef FROUND_FLAGS_EN
              chk($sformatf("out_nx inst=%0d tag=%0d", i, ce.tag), 32'(onx[i]), 32'(ce.nx));
              chk($sformatf("out_nv inst=%0d tag=%0d", i, ce.tag), 32'(onv[i]), 32'(ce.nv));
`endif
              rd[i]++;
              seen[i] = 1'b0;
            end
          end
        end
        if (inv[i] && rdy[i]) begin
          ce.y          = ref_round(in_x, in_rm);
          ce.tag        = in_tag;
          ce.nv         = ref_nv(in_x);
          ce.nx         = in_x[30:23] != 8'hFF && ce.y != in_x;
          ce.acc_cyc    = cyc;
          ce.acc_stalls = stalls[i];
          sb[i][wr[i] % 64] = ce;
          wr[i]++;
        end
        if (ov[i] && !ordy[i]) stalls[i]++;
      end
      cyc++;
    end
  end

  task automatic send(input int s, input logic [31:0] x, input logic [2:0] rm,
                      input logic [4:0] tag);
    logic acc;
    in_x = x; in_rm = rm; in_tag = tag;
    inv[s] = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = rdy[s];
      @(posedge clk);
      #1;
    end
    inv[s] = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout inst=%0d: got in_ready=0 want 1 within 100 cycles", s);
    end
  endtask

  task automatic drain(input int s);
    for (int k = 0; k < 300 && rd[s] != wr[s]; k++) @(posedge clk);
    #1;
    chk($sformatf("drain inst=%0d outstanding", s), 32'(wr[s] - rd[s]), 32'd0);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [2:0]  rm;
    logic [31:0] y;
  } vec_t;

  vec_t vecs [$];
  logic done;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish before 400us");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; inv = '0; ordy = 2'b11;
    in_x = '0; in_rm = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset out_valid inst=%0d", s), 32'(ov[s]), 32'd0);
      chk($sformatf("reset out_y inst=%0d", s), oy[s], 32'd0);
      chk($sformatf("reset out_tag inst=%0d", s), 32'(otag[s]), 32'd0);
      chk($sformatf("reset in_ready inst=%0d", s), 32'(rdy[s]), 32'd1);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with hand-computed results.
    vecs.push_back('{32'hC0200000, 3'd0, 32'hC0000000});
    vecs.push_back('{32'hC0200000, 3'd1, 32'hC0000000});
    vecs.push_back('{32'hC0200000, 3'd2, 32'hC0400000});
    vecs.push_back('{32'hC0200000, 3'd3, 32'hC0000000});
    vecs.push_back('{32'hC0200000, 3'd4, 32'hC0400000});
    vecs.push_back('{32'h3F000000, 3'd0, 32'h00000000});
    vecs.push_back('{32'h3F000000, 3'd4, 32'h3F800000});
    vecs.push_back('{32'h3FC00000, 3'd0, 32'h40000000});
    vecs.push_back('{32'hBE800000, 3'd2, 32'hBF800000});
    vecs.push_back('{32'hBE800000, 3'd3, 32'h80000000});
    vecs.push_back('{32'h3F7FFFFF, 3'd3, 32'h3F800000});
    vecs.push_back('{32'h3FFFFFFF, 3'd0, 32'h40000000});
    vecs.push_back('{32'h80000000, 3'd2, 32'h80000000});
    vecs.push_back('{32'hBF000000, 3'd3, 32'h80000000});
    vecs.push_back('{32'h3FC00000, 3'd6, 32'h40000000});
    vecs.push_back('{32'h40500000, 3'd1, 32'h40400000});
    for (int r = 0; r < 5; r++) begin
      vecs.push_back('{32'h4B000001, 3'(r), 32'h4B000001});
      vecs.push_back('{32'h7F800000, 3'(r), 32'h7F800000});
      vecs.push_back('{32'h7FC00000, 3'(r), 32'h7FC00000});
    end
`ifdef FROUND_FLAGS_EN
    vecs.push_back('{32'h7F800001, 3'd0, 32'h7FC00001});
    chk("model nv 7F800001", 32'(ref_nv(32'h7F800001)), 32'd1);
`endif
    foreach (vecs[k]) begin
      chk($sformatf("model x=%h rm=%0d", vecs[k].x, vecs[k].rm),
          ref_round(vecs[k].x, vecs[k].rm), vecs[k].y);
      send(k % 2, vecs[k].x, vecs[k].rm, 5'(k));
    end
    drain(0); drain(1);

    // Back-pressure: 6 back-to-back ops, output held off 3 cycles at the first result.
    for (int s = 0; s < 2; s++) begin
      int base;
      base = rd[s];
      fork
        begin
          for (int t = 0; t < 6; t++) send(s, 32'h40100000 + 32'(t) * 32'h00100000, 3'(t % 5), 5'(t));
        end
        begin
          logic got;
          got = 1'b0;
          for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            got = ov[s];
          end
          chk($sformatf("bp first result inst=%0d", s), 32'(got), 32'd1);
          ordy[s] = 1'b0;
          for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp in_ready stalled inst=%0d", s), 32'(rdy[s]), 32'd0);
            @(posedge clk); #1;
          end
          ordy[s] = 1'b1;
        end
      join
      drain(s);
      chk($sformatf("bp result count inst=%0d", s), 32'(rd[s] - base), 32'd6);
    end

    // Random operands with random back-pressure.
    for (int s = 0; s < 2; s++) begin
      done = 1'b0;
      fork
        begin
          for (int k = 0; k < 40; k++) begin
            logic [31:0] x;
            x = $urandom;
            if (k % 2 == 1) x[30:23] = 8'($urandom_range(120, 152));
            send(s, x, 3'($urandom_range(0, 7)), 5'(k));
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk); #1;
            ordy[s] = ($urandom_range(0, 3) != 0);
          end
          ordy[s] = 1'b1;
        end
      join
      drain(s);
    end

    // Reset mid-stream with results in flight and one held at the output.
    for (int s = 0; s < 2; s++) begin
      logic got;
      ordy[s] = 1'b0;
      for (int t = 0; t < 3; t++) send(s, 32'h3FC00000, 3'd0, 5'(20 + t));
      got = ov[s];
      for (int k = 0; k < 20 && !got; k++) begin
        @(posedge clk); #1;
        got = ov[s];
      end
      chk($sformatf("rst pre out_valid inst=%0d", s), 32'(got), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk($sformatf("rst async out_valid inst=%0d", s), 32'(ov[s]), 32'd0);
      chk($sformatf("rst async out_y inst=%0d", s), oy[s], 32'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      ordy[s] = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        chk($sformatf("rst no stale result inst=%0d", s), 32'(ov[s]), 32'd0);
      end
      @(posedge clk); #1;
      send(s, 32'hBFC00000, 3'd4, 5'd31);
      drain(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fround_pipe.md
Name: fround_pipe

Overview:
- Pipelined FP32 round-to-integral-value unit; successor to the fixed floor-only unit.
- Per-operation rounding mode: RNE, RTZ, RDN (floor), RUP (ceil), RMM.
- Pure bit-manipulation datapath: mask the fraction bits, then conditionally increment. No int<->float round trip.
- Valid/ready handshake with tag passthrough. Sits in the FPU beside the conversion units and is driven by the issue stage.

Parameters:
- STAGES, 3: accepted-input to out_valid latency in cycles; minimum 3; stages beyond 3 are pure delay registers.
- TAG_W, 5: width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operation present
- in_ready  out  1  unit can accept this cycle
- in_x  in  32  IEEE-754 single operand
- in_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out_y  out  32  rounded result
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Reset: all stage valid bits, out_valid, out_y and out_tag are 0. in_ready is 1 after reset.
- Stall is global. stall = out_valid & ~out_ready; in_ready = ~stall.
- While stalled, every stage register holds its value. Transfer occurs when in_valid & in_ready.
- Latency is exactly STAGES cycles with no stall. Throughput is 1 per cycle. Results emerge in order; no loss or duplication.
- Reset asserted mid-operation clears all in-flight operations immediately (asynchronous). No stale result appears after release.
- Stage 1 (classify):
  - e = x[30:23].
  - e==255 (Inf/NaN): pass through unchanged.
  - e>=150: value is already integral; pass through.
  - e<127: small path.
  - Otherwise: frac count f = 150-e, range 1..23.
- Stage 2 (decide):
  - Normal path: mask = (1<<f)-1. Compute inexact = |(x&mask); half = bit f-1; sticky = any bit below f-1; lsb = bit f.
  - Round-up condition per mode:
    - RNE: half & (sticky | lsb)
    - RTZ: 0
    - RDN: sign & inexact
    - RUP: ~sign & inexact
    - RMM: half
  - Small path (|x|<1): magnitude-one condition per mode:
    - RNE: e==126 & mantissa!=0
    - RMM: e==126
    - RDN: sign & nonzero
    - RUP: ~sign & nonzero
    - RTZ: never
    - Zero input (x[30:0]==0) never rounds up.
- Stage 3 (assemble):
  - Normal path: y = {sign, (x[30:0] & ~mask) + (up ? (1<<f) : 0)}. The carry propagates into the exponent naturally; the result never exceeds 2^24, so no overflow.
  - Small path: y = {sign, up ? 0x3F800000[30:0] : 31'b0}.
- Sign is always preserved: floor(-0.0)=0x80000000; ceil(-0.5)=0x80000000.
- Illegal rm (101..111) is treated as RNE.

Optional Feature:
- Macro: FROUND_FLAGS_EN.
- Defined: adds output ports out_nx (1) and out_nv (1), aligned with out_y.
  - out_nx = finite input and result != input.
  - out_nv = signalling NaN input (e==255, mantissa!=0, x[22]==0). An sNaN input is quieted: out_y = x | 0x00400000.
  - Both flags reset to 0.
- Undefined: ports are absent and NaNs pass bit-exact.

Decomposition:
- Package fround_pkg holds:
  - rm_e enum: RNE, RTZ, RDN, RUP, RMM.
  - Constants FP_BIAS=127, FP_EXP_INT=150, FP_ONE=32'h3F800000, FP_QBIT=32'h00400000.
  - Stage payload struct types.
- Sub-module fround_core holds the three combinational stage functions. fround_pipe owns the registers, stall and valid/tag shift chain.

Test Plan:
- -2.5 (0xC0200000) in each mode gives:
  - RNE 0xC0000000
  - RTZ 0xC0000000
  - RDN 0xC0400000
  - RUP 0xC0000000
  - RMM 0xC0400000
- Ties and small values:
  - 0.5 (0x3F000000): RNE -> 0x00000000, RMM -> 0x3F800000.
  - 1.5 (0x3FC00000): RNE -> 0x40000000.
  - -0.25 (0xBE800000): RDN -> 0xBF800000, RUP -> 0x80000000.
- Carry into exponent: 0x3F7FFFFF with RUP -> 0x3F800000; 0x3FFFFFFF with RNE -> 0x40000000.
- Passthrough: 0x4B000001, 0x7F800000 and 0x7FC00000 unchanged in all modes. With FROUND_FLAGS_EN, 0x7F800001 -> 0x7FC00001 and out_nv=1.
- Back-pressure: 6 back-to-back ops with tags 0..5; hold out_ready=0 for 3 cycles at the first result.
  - in_ready must drop during the stall.
  - Results must appear with tags 0..5 in order, with correct values and no duplicates.
  - Latency must be STAGES cycles; run once with STAGES=3 and once with STAGES=5.
- Reset mid-stream: assert rst with 2 ops in flight.
  - out_valid goes to 0 without waiting for a clk edge.
  - After release, no result appears until a new input is accepted.
